// File: rtl/mips_main_ctrl_if.sv
// Opcode/enable bundle into the main control decoder and the registered control word out of it.
// Master is the fetch/decode side; slave is the decoder.
interface mips_main_ctrl_if;
  logic       en;
  logic       flush;
  logic [5:0] opCode;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       BranchNe;
  logic       Jump;
  logic [1:0] ALUOp;
  logic [1:0] ImmFunc;
  logic       illegal_op;

  modport master (
    output en, flush, opCode,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, BranchNe, Jump, ALUOp, ImmFunc, illegal_op
  );

  modport slave (
    input  en, flush, opCode,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, BranchNe, Jump, ALUOp, ImmFunc, illegal_op
  );
endinterface

// File: rtl/mips_main_ctrl.sv
// MIPS main control decoder; MAIN_CTRL_EXT_OPS_EN adds bne/j/addi/andi/ori/slti.
// Latency 1 cycle, outputs straight from flops; en=0 holds, flush loads a bubble.
module mips_main_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  mips_main_ctrl_if.slave       ctrlIf
);

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       branchNe;
    logic       jump;
    logic [1:0] aluOp;
    logic [1:0] immFunc;
    logic       illegalOp;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MAIN_CTRL_EXT_OPS_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

  ctrl_t ctrlD;
  ctrl_t ctrlQ;

  always_comb begin
    ctrlD = '0;
    unique case (ctrlIf.opCode)
      OP_RTYPE: begin
        ctrlD.regDst   = 1'b1;
        ctrlD.regWrite = 1'b1;
        ctrlD.aluOp    = 2'b10;
      end
      OP_LW: begin
        ctrlD.aluSrc   = 1'b1;
        ctrlD.memToReg = 1'b1;
        ctrlD.regWrite = 1'b1;
        ctrlD.memRead  = 1'b1;
      end
      OP_SW: begin
        ctrlD.aluSrc   = 1'b1;
        ctrlD.memWrite = 1'b1;
      end
      OP_BEQ: begin
        ctrlD.branch = 1'b1;
        ctrlD.aluOp  = 2'b01;
      end
`ifdef MAIN_CTRL_EXT_OPS_EN
      OP_BNE: begin
        ctrlD.branch   = 1'b1;
        ctrlD.branchNe = 1'b1;
        ctrlD.aluOp    = 2'b01;
      end
      OP_J: begin
        ctrlD.jump = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrlD.aluSrc   = 1'b1;
        ctrlD.regWrite = 1'b1;
        ctrlD.aluOp    = 2'b11;
        // ImmFunc encodes the immediate ALU op: add, and, or, slt.
        case (ctrlIf.opCode)
          OP_ANDI: ctrlD.immFunc = 2'b01;
          OP_ORI:  ctrlD.immFunc = 2'b10;
          OP_SLTI: ctrlD.immFunc = 2'b11;
          default: ctrlD.immFunc = 2'b00;
        endcase
      end
`endif
      default: begin
        ctrlD.illegalOp = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlQ <= '0;
    end else if (ctrlIf.flush) begin
      ctrlQ <= '0;
    end else if (ctrlIf.en) begin
      ctrlQ <= ctrlD;
    end
  end

  assign ctrlIf.RegDst     = ctrlQ.regDst;
  assign ctrlIf.ALUSrc     = ctrlQ.aluSrc;
  assign ctrlIf.MemtoReg   = ctrlQ.memToReg;
  assign ctrlIf.RegWrite   = ctrlQ.regWrite;
  assign ctrlIf.MemRead    = ctrlQ.memRead;
  assign ctrlIf.MemWrite   = ctrlQ.memWrite;
  assign ctrlIf.Branch     = ctrlQ.branch;
  assign ctrlIf.BranchNe   = ctrlQ.branchNe;
  assign ctrlIf.Jump       = ctrlQ.jump;
  assign ctrlIf.ALUOp      = ctrlQ.aluOp;
  assign ctrlIf.ImmFunc    = ctrlQ.immFunc;
  assign ctrlIf.illegal_op = ctrlQ.illegalOp;

  // Structural hazards the datapath relies on never seeing.
  assert property (@(posedge clk) disable iff (reset) !(ctrlQ.memRead && ctrlQ.memWrite));
  assert property (@(posedge clk) disable iff (reset) !(ctrlQ.regWrite && ctrlQ.memWrite));
  assert property (@(posedge clk) disable iff (reset) !(ctrlQ.branch && ctrlQ.jump));
  assert property (@(posedge clk) disable iff (reset) !ctrlQ.branchNe || ctrlQ.branch);

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl: expected control words are queued as stimulus is
// driven and compared one cycle later; extended-opcode expectations follow MAIN_CTRL_EXT_OPS_EN.
module tb_mips_main_ctrl;
  logic clk = 1'b0;
  logic reset;

  mips_main_ctrl_if bus();

  mips_main_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .ctrlIf (bus.slave)
  );

  always #5 clk = ~clk;

  // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,Jump,ALUOp,ImmFunc,illegal_op}
  logic [13:0] obs;
  assign obs = {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
                bus.Branch, bus.BranchNe, bus.Jump, bus.ALUOp, bus.ImmFunc, bus.illegal_op};

  logic [13:0] sb[$];
  logic [13:0] model;
  logic [13:0] got;
  logic [13:0] want;
  int checks = 0;
  int errors = 0;

  localparam logic [13:0] BUBBLE = 14'b0;

  function automatic logic [13:0] expDecode(input logic [5:0] op);
    case (op)
      6'b000000: return {9'b100100000, 2'b10, 2'b00, 1'b0};
      6'b100011: return {9'b011110000, 2'b00, 2'b00, 1'b0};
      6'b101011: return {9'b010001000, 2'b00, 2'b00, 1'b0};
      6'b000100: return {9'b000000100, 2'b01, 2'b00, 1'b0};
`ifdef MAIN_CTRL_EXT_OPS_EN
      6'b000101: return {9'b000000110, 2'b01, 2'b00, 1'b0};
      6'b000010: return {9'b000000001, 2'b00, 2'b00, 1'b0};
      6'b001000: return {9'b010100000, 2'b11, 2'b00, 1'b0};
      6'b001100: return {9'b010100000, 2'b11, 2'b01, 1'b0};
      6'b001101: return {9'b010100000, 2'b11, 2'b10, 1'b0};
      6'b001010: return {9'b010100000, 2'b11, 2'b11, 1'b0};
`endif
      default:   return {9'b000000000, 2'b00, 2'b00, 1'b1};
    endcase
  endfunction

  // Drive one cycle of stimulus, queue the expected registered result, sample after the edge.
  task automatic step(input logic r, input logic f, input logic e, input logic [5:0] op);
    @(negedge clk);
    reset      = r;
    bus.flush  = f;
    bus.en     = e;
    bus.opCode = op;
    if (r || f) model = BUBBLE;
    else if (e) model = expDecode(op);
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 6'b000000);
    step(1'b1, 1'b0, 1'b0, 6'b000000);
    for (int i = 0; i < 2; i++) begin
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (i == 1 && got !== want) begin
        errors++;
        $display("FAIL reset_hold got=%b want=%b", got, want);
      end
    end
    step(1'b0, 1'b0, 1'b1, 6'b000000);
    want = sb.pop_front();
    got  = obs;
    checks++;
    if (got !== want || want !== {9'b100100000, 2'b10, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_rtype got=%b want=%b", got, want);
    end
  endtask

  task automatic test_mem_branch();
    logic [5:0] ops[3];
    ops = '{6'b100011, 6'b101011, 6'b000100};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, ops[i]);
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_branch op=%b got=%b want=%b", ops[i], got, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2];
    ops = '{6'b011001, 6'b000000};
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, ops[i]);
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (got !== want || got[0] !== (i == 0)) begin
        errors++;
        $display("FAIL illegal op=%b got=%b want=%b", ops[i], got, want);
      end
    end
  endtask

  task automatic test_ext_ops();
    logic [5:0] ops[6];
    ops = '{6'b001101, 6'b000101, 6'b000010, 6'b001000, 6'b001100, 6'b001010};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, ops[i]);
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ext_ops op=%b got=%b want=%b", ops[i], got, want);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 1'b1, 6'b100011);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 6'b101011);
    step(1'b0, 1'b0, 1'b1, 6'b101011);
    for (int i = 0; i < 5; i++) begin
      want = sb.pop_front();
      checks++;
      if (i == 4) begin
        got = obs;
        if (got !== want) begin
          errors++;
          $display("FAIL hold_release got=%b want=%b", got, want);
        end
      end else if (want !== {9'b011110000, 2'b00, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL hold_model_%0d got=%b want=lw", i, want);
      end
    end
  endtask

  task automatic test_hold_observed();
    // Same scenario, each held cycle compared against the DUT as it happens.
    step(1'b0, 1'b0, 1'b1, 6'b100011);
    want = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 6'b101011);
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold_cycle%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_flush_reset();
    step(1'b0, 1'b0, 1'b1, 6'b000000);
    want = sb.pop_front();
    step(1'b0, 1'b1, 1'b1, 6'b100011);
    want = sb.pop_front();
    got  = obs;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL flush got=%b want=%b", got, want);
    end
    step(1'b0, 1'b0, 1'b1, 6'b011111);
    want = sb.pop_front();
    step(1'b1, 1'b1, 1'b1, 6'b100011);
    want = sb.pop_front();
    got  = obs;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_and_flush got=%b want=%b", got, want);
    end
    step(1'b0, 1'b0, 1'b1, 6'b100011);
    want = sb.pop_front();
    step(1'b1, 1'b0, 1'b1, 6'b100011);
    want = sb.pop_front();
    got  = obs;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_mid got=%b want=%b", got, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pool[12];
    logic [5:0] op;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
             6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b111111, 6'b011001};
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
      step(1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), op);
      want = sb.pop_front();
      got  = obs;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back i=%0d op=%b got=%b want=%b", i, op, got, want);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.flush  = 1'b0;
    bus.en     = 1'b0;
    bus.opCode = 6'b000000;
    model      = BUBBLE;
    test_reset();
    test_mem_branch();
    test_illegal();
    test_ext_ops();
    test_hold();
    test_hold_observed();
    test_flush_reset();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
- Main control decoder for a single-issue MIPS datapath.
- Decodes the 6-bit instruction opcode into datapath steering and enable signals: register destination select, ALU source, memory read/write, writeback select, branch/jump, and ALU operation class.
- Outputs are registered, with one cycle of latency, so they can feed a pipeline stage boundary.
- Sits between the instruction fetch/decode stage and the datapath and ALU control unit.

Parameters:
- None. The opcode width is fixed at 6 bits and the ALUOp width at 2 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- en  in  1  decode enable; when 0, all outputs hold their values.
- flush  in  1  when 1, a bubble is loaded (all outputs 0).
- opCode  in  6  instruction bits [31:26].
- RegDst  out  1  1 = write register comes from rd; 0 = from rt.
- ALUSrc  out  1  1 = ALU operand B is the sign-extended immediate.
- MemtoReg  out  1  1 = writeback data comes from memory.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- Branch  out  1  conditional branch instruction.
- BranchNe  out  1  branch is taken on not-equal (bne).
- Jump  out  1  unconditional jump.
- ALUOp  out  2  00 = add (address), 01 = subtract (compare), 10 = R-type (use funct), 11 = immediate op.
- ImmFunc  out  2  valid only when ALUOp = 11: 00 = add, 01 = and, 10 = or, 11 = slt.
- illegal_op  out  1  the opcode just decoded is unsupported.

Behaviour:
- All outputs are registered and update on the rising edge of clk.
- Latency:
  - An opCode present at edge N drives the outputs after edge N.
  - The outputs are fully combinational-free (flop outputs only).
- Priority at each edge: reset, then flush, then en, then hold.
  - reset = 1: every output goes to 0, including ALUOp = 00, ImmFunc = 00 and illegal_op = 0.
  - flush = 1 (reset = 0): same all-zero bubble as reset.
  - en = 1: load the decode of opCode.
  - en = 0: hold the previous values.
- Reset mid-operation: the outputs are zero the cycle after reset is sampled. The first decode is loaded at the first edge with reset = 0 and en = 1.
- Decode table. Outputs are listed as RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNe, Jump, ALUOp, ImmFunc. Any signal not listed is 0.
  - 000000 R-type: 1,0,0,1,0,0,0,0,0,10,00.
  - 100011 lw: 0,1,1,1,1,0,0,0,0,00,00.
  - 101011 sw: 0,1,0,0,0,1,0,0,0,00,00. Don't-cares are driven as 0.
  - 000100 beq: 0,0,0,0,0,0,1,0,0,01,00.
  - Extended opcodes (see Optional Feature):
    - 000101 bne: as beq, with BranchNe = 1.
    - 000010 j: Jump = 1, all other outputs 0.
    - 001000 addi: ALUSrc = 1, RegWrite = 1, ALUOp = 11, ImmFunc = 00.
    - 001100 andi: as addi, with ImmFunc = 01.
    - 001101 ori: as addi, with ImmFunc = 10.
    - 001010 slti: as addi, with ImmFunc = 11.
- Any other opcode:
  - All control outputs are 0, so there are no register or memory writes.
  - illegal_op = 1.
  - illegal_op is registered alongside the decode and clears on the next legal decode, flush or reset.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite and MemWrite are never both 1.
  - Branch and Jump are never both 1.
  - BranchNe = 1 implies Branch = 1.

Optional Feature:
- Macro: MAIN_CTRL_EXT_OPS_EN.
- Defined:
  - Decodes bne, j, addi, andi, ori and slti as in the table.
- Undefined:
  - Only R-type, lw, sw and beq are decoded.
  - The extended opcodes are treated as illegal: all control outputs 0, illegal_op = 1.
  - BranchNe, Jump and ImmFunc are tied to 0. The ports remain present.

Test Plan:
- Reset held for 2 cycles with opCode = 000000 -> every output 0. Release reset with en = 1 -> the next edge gives RegDst = 1, RegWrite = 1, ALUOp = 10, all others 0.
- opCode sequence 100011, 101011, 000100 with one per cycle -> one cycle later each:
  - lw: ALUSrc = MemtoReg = RegWrite = MemRead = 1, ALUOp = 00.
  - sw: ALUSrc = MemWrite = 1, ALUOp = 00.
  - beq: Branch = 1, ALUOp = 01.
  - illegal_op = 0 throughout.
- opCode = 011001 -> all control outputs 0, illegal_op = 1. The next opCode = 000000 clears illegal_op to 0.
- With MAIN_CTRL_EXT_OPS_EN:
  - 001101 -> ALUSrc = 1, RegWrite = 1, ALUOp = 11, ImmFunc = 10.
  - 000101 -> Branch = 1, BranchNe = 1, ALUOp = 01.
  - 000010 -> Jump = 1.
  - Without the macro, the same opcodes give illegal_op = 1 and zero controls.
- Decode lw, then drop en to 0 while opCode = 101011 for 3 cycles -> the lw outputs hold. Raise en -> the sw decode appears one cycle later.
- flush = 1 with en = 1 and opCode = 100011 -> all outputs 0. reset and flush asserted together -> all outputs 0. Assert reset mid-sequence with en = 1 -> zeros on the next edge.
